vit_traceback: RTL and testbench

//  Survivor-memory reader for the Viterbi decoder: the read side of the ram_dp survivor RAM written by the ACS unit.
//  On start it walks decision words backwards from the newest stage, one stage per cycle.
//  The first TBLEN stages are used only for path convergence. The next DLEN stages yield decoded bits.
//  A LIFO reverses those bits, which are emitted oldest-first on a valid/ready stream.

---
 rtl/vitdec_pkg.sv | 23 ++
 rtl/tb_lifo.sv | 48 ++++
 rtl/vit_traceback.sv | 135 +++++++++++++
 tb/tb_vit_traceback.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vitdec_pkg.sv
// Shared types and helpers for the Viterbi decoder blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vitdec_pkg;

  localparam int K_DEF      = 7;
  localparam int NSTATE_DEF = 2 ** (K_DEF - 1);

  typedef enum logic [1:0] {
    TB_IDLE   = 2'd0,
    TB_TRACE  = 2'd1,
    TB_OUTPUT = 2'd2
  } tb_fsm_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/tb_lifo.sv
// Bit stack reversing traceback order so decoded bits leave oldest-first.
// Latency: push/pop take effect at the next clock; top is a flop output.
// Backpressure: none internally; push when full and pop when empty are ignored.
// Ports: clock, rst_n (sync, active-low), clear, push+din, pop, top, empty, count.
module tb_lifo
  import vitdec_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          push,
  input  logic                          din,
  input  logic                          pop,
  output logic                          top,
  output logic                          empty,
  output logic [clog2(DEPTH + 1)-1:0]   count
);

  localparam int CW = clog2(DEPTH + 1);

  // Shift-register stack: element 0 is the top, so pop is a right shift.
  logic [DEPTH-1:0] stack;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign top     = stack[0];
  assign empty   = (count == '0);

  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      stack <= '0;
      count <= '0;
    end else if (do_push && do_pop) begin
      stack <= {stack[DEPTH-1:1], din};
    end else if (do_push) begin
      stack <= {stack[DEPTH-2:0], din};
      count <= count + CW'(1);
    end else if (do_pop) begin
      stack <= {1'b0, stack[DEPTH-1:1]};
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/vit_traceback.sv
// Viterbi survivor-memory traceback: walks TBLEN+DLEN stages back from the newest, emits DLEN bits oldest-first.
// Latency: first dout_valid TBLEN+DLEN+2 cycles after the start cycle; one RAM read per cycle.
// Backpressure: dout/dout_last held while dout_ready=0; start ignored until busy drops.
// Ports: clock, rst_n (sync, active-low); start/start_addr/start_state request; busy;
//        raddr/rdata survivor RAM read port (1-cycle registered read); dout/dout_valid/dout_ready/dout_last stream.
module vit_traceback
  import vitdec_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int ASIZE = 7,
  parameter int TBLEN = 32,
  parameter int DLEN  = 32
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ASIZE-1:0]      start_addr,
  input  logic [K-2:0]          start_state,
  output logic                  busy,
  output logic [ASIZE-1:0]      raddr,
  input  logic [2**(K-1)-1:0]   rdata,
  output logic                  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam int N  = TBLEN + DLEN;
  localparam int CW = clog2(N + 1);
  localparam int LW = clog2(DLEN + 1);

  tb_fsm_t       state;
  logic [CW-1:0] iss_cnt;   // reads issued so far
  logic [CW-1:0] proc_cnt;  // stages processed so far
  logic          rd_vld;    // rdata this cycle belongs to an issued read
  logic [K-2:0]  tb_state;

  logic          dec_bit;
  logic          dec_d;
  logic          hs;
  logic          lifo_push;
  logic          lifo_pop;
  logic          lifo_clear;
  logic          lifo_top;
  logic          lifo_empty;
  logic [LW-1:0] lifo_count;

  // The decoded bit is the input that entered the current state (its MSB);
  // the decision bit selects the predecessor's LSB.
  assign dec_bit    = tb_state[K-2];
  assign dec_d      = rdata[tb_state];
  assign hs         = dout_valid && dout_ready;
  assign lifo_push  = (state == TB_TRACE) && rd_vld && (proc_cnt >= CW'(TBLEN));
  assign lifo_pop   = (state == TB_OUTPUT) && hs && !lifo_empty;
  assign lifo_clear = (state == TB_IDLE) && start && !busy;
  assign dout       = lifo_top;

  tb_lifo #(
    .DEPTH (DLEN)
  ) u_lifo (
    .clock (clock),
    .rst_n (rst_n),
    .clear (lifo_clear),
    .push  (lifo_push),
    .din   (dec_bit),
    .pop   (lifo_pop),
    .top   (lifo_top),
    .empty (lifo_empty),
    .count (lifo_count)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state      <= TB_IDLE;
      busy       <= 1'b0;
      raddr      <= '0;
      iss_cnt    <= '0;
      proc_cnt   <= '0;
      rd_vld     <= 1'b0;
      tb_state   <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      case (state)
        TB_IDLE: begin
          if (start && !busy) begin
            raddr    <= start_addr;
            tb_state <= start_state;
            busy     <= 1'b1;
            iss_cnt  <= '0;
            proc_cnt <= '0;
            rd_vld   <= 1'b0;
            state    <= TB_TRACE;
          end
        end

        TB_TRACE: begin
          // Issue side: raddr already shows read iss_cnt; hold it after the last one.
          rd_vld <= (iss_cnt < CW'(N));
          if (iss_cnt < CW'(N)) begin
            iss_cnt <= iss_cnt + CW'(1);
            if (iss_cnt < CW'(N - 1)) raddr <= raddr - 1'b1;
          end
          // Process side, one cycle behind the issue side.
          if (rd_vld) begin
            tb_state <= {tb_state[K-3:0], dec_d};
            proc_cnt <= proc_cnt + CW'(1);
            if (proc_cnt == CW'(N - 1)) begin
              state      <= TB_OUTPUT;
              dout_valid <= 1'b1;
              dout_last  <= (DLEN == 1);
            end
          end
        end

        TB_OUTPUT: begin
          if (hs) begin
            if (dout_last) begin
              state      <= TB_IDLE;
              busy       <= 1'b0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
            end else begin
              // After this pop exactly one bit remains when two are stacked now.
              dout_last <= (lifo_count == LW'(2));
            end
          end
        end

        default: state <= TB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vit_traceback.sv
// Self-checking bench for vit_traceback with a behavioural survivor RAM.
// Latency: n/a.
// Backpressure: drives dout_ready with steady, patterned and random sequences.
module tb_vit_traceback;

  localparam int K     = 7;
  localparam int ASIZE = 7;
  localparam int TBLEN = 32;
  localparam int DLEN  = 32;
  localparam int N     = TBLEN + DLEN;
  localparam logic [6:0] G0 = 7'o171;
  localparam logic [6:0] G1 = 7'o133;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [ASIZE-1:0] start_addr = '0;
  logic [K-2:0]     start_state = '0;
  logic             busy;
  logic [ASIZE-1:0] raddr;
  logic [63:0]      rdata;
  logic             dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             dout_last;

  logic [63:0] mem [0:127];

  int errors = 0;
  int checks = 0;

  bit         got_bits[$];
  bit         got_last[$];
  bit         exp_bits[$];
  logic [6:0] raddr_log[$];
  int         first_valid_k;
  int         stall_viol;
  logic       busy_after;
  logic       valid_after;

  vit_traceback #(
    .K     (K),
    .ASIZE (ASIZE),
    .TBLEN (TBLEN),
    .DLEN  (DLEN)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .start_state (start_state),
    .busy        (busy),
    .raddr       (raddr),
    .rdata       (rdata),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last)
  );

  always #5 clock = ~clock;

  // Survivor RAM: registered read, data one cycle after the address.
  always @(posedge clock) rdata <= mem[raddr];

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 128; i++) begin
      case (mode)
        0:       mem[i] = '0;
        1:       mem[i] = '1;
        default: mem[i] = {$urandom, $urandom};
      endcase
    end
  endtask

  // Traceback from the spec rules: follow decisions backwards, keep the last DLEN, oldest first.
  task automatic ref_model(input logic [6:0] a, input logic [5:0] st);
    logic [5:0] s;
    logic [6:0] ad;
    logic       d;
    exp_bits.delete();
    s = st;
    for (int i = 0; i < N; i++) begin
      ad = a - 7'(i);
      d  = mem[ad][s];
      if (i >= TBLEN) exp_bits.push_front(s[5]);
      s = {s[4:0], d};
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  function automatic logic [31:0] got_vec();
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < got_bits.size() && j < 32; j++) v[31-j] = got_bits[j];
    return v;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < exp_bits.size() && j < 32; j++) v[31-j] = exp_bits[j];
    return v;
  endfunction

  // Index of the single last flag, -1 if there is not exactly one.
  function automatic int last_pos();
    int p;
    int n;
    p = -1;
    n = 0;
    for (int j = 0; j < got_last.size(); j++) if (got_last[j]) begin p = j; n++; end
    return (n == 1) ? p : -1;
  endfunction

  function automatic int raddr_bad(input logic [6:0] a);
    int         bad;
    logic [6:0] e;
    bad = 0;
    if (raddr_log.size() != N + 1) return 1000;
    for (int i = 0; i <= N; i++) begin
      e = a - 7'((i < N) ? i : N - 1);
      if (raddr_log[i] !== e) bad++;
    end
    return bad;
  endfunction

  // Entered at #1 after a posedge (or at the negedge of a chained start cycle).
  task automatic run_block(input logic [6:0] a, input logic [5:0] st, input int mode,
                           input bit pulse_mid, input bit chain,
                           input logic [6:0] na, input logic [5:0] nst);
    int k;
    int hs;
    bit done;
    bit prev_stall;
    bit prev_d;
    bit prev_l;
    got_bits.delete();
    got_last.delete();
    raddr_log.delete();
    first_valid_k = -1;
    stall_viol = 0;
    done = 0;
    hs = 0;
    prev_stall = 0;
    prev_d = 0;
    prev_l = 0;
    start = 1'b1;
    start_addr = a;
    start_state = st;
    dout_ready = ready_for(mode, 0);
    @(posedge clock); #1;
    start = 1'b0;
    start_addr = 7'($urandom);
    start_state = 6'($urandom);
    k = 1;
    dout_ready = ready_for(mode, 1);
    while (!done && k < 600) begin
      @(negedge clock);
      if (k <= N + 1) raddr_log.push_back(raddr);
      if (dout_valid && first_valid_k < 0) first_valid_k = k;
      if (prev_stall && (!dout_valid || dout !== prev_d || dout_last !== prev_l)) stall_viol++;
      prev_stall = dout_valid && !dout_ready;
      prev_d = dout;
      prev_l = dout_last;
      if (dout_valid === 1'b1 && dout_ready) begin
        got_bits.push_back(dout);
        got_last.push_back(dout_last);
        hs++;
        if (dout_last === 1'b1) done = 1;
      end
      @(posedge clock); #1;
      k++;
      start = pulse_mid && (hs == 5 || hs == 6);
      dout_ready = ready_for(mode, k);
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL block_timeout: handshakes=%0d after %0d cycles, required final dout_last", hs, k);
    end
    if (chain) begin
      start = 1'b1;
      start_addr = na;
      start_state = nst;
    end
    @(negedge clock);
    busy_after = busy;
    valid_after = dout_valid;
    if (!chain) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (raddr !== 7'd0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", dout_last); end
    @(posedge clock); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_zeros();
    fill_mem(0);
    ref_model(7'd63, 6'd0);
    run_block(7'd63, 6'd0, 0, 0, 0, 7'd0, 6'd0);
    checks++; if (got_bits.size() != 32) begin errors++; $display("FAIL t1_count: got %0d want 32", got_bits.size()); end
    checks++; if (got_vec() !== exp_vec()) begin errors++; $display("FAIL t1_bits: got %h want %h", got_vec(), exp_vec()); end
    checks++; if (last_pos() != 31) begin errors++; $display("FAIL t1_last_pos: got %0d want 31", last_pos()); end
    checks++; if (first_valid_k != N + 2) begin errors++; $display("FAIL t1_first_valid: got c0+%0d want c0+%0d", first_valid_k, N + 2); end
    checks++; if (raddr_bad(7'd63) != 0) begin errors++; $display("FAIL t1_raddr: %0d wrong addresses", raddr_bad(7'd63)); end
  endtask

  task automatic test_ones();
    logic [31:0] want;
    want = '1;
    fill_mem(1);
    run_block(7'd100, 6'd63, 0, 0, 0, 7'd0, 6'd0);
    checks++; if (got_vec() !== want || got_bits.size() != 32) begin errors++; $display("FAIL t2_bits: got %h (%0d bits) want %h", got_vec(), got_bits.size(), want); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL t2_busy_drop: got %b want 0", busy_after); end
    checks++; if (valid_after !== 1'b0) begin errors++; $display("FAIL t2_valid_drop: got %b want 0", valid_after); end
  endtask

  // Encode a message, run a hard-decision ACS over the noiseless symbols, store decisions.
  task automatic test_golden();
    logic [63:0] msg;
    logic [31:0] want;
    logic [5:0]  s;
    logic [5:0]  ns6;
    logic [5:0]  ps;
    logic [6:0]  w;
    logic [63:0] word;
    logic        e0;
    logic        e1;
    logic        b;
    int          pm[64];
    int          npm[64];
    int          m;
    int          best;
    logic        bd;
    msg  = 64'hDEADBEEF_A5A5C3C3;
    want = msg[63:32];
    fill_mem(2);
    for (int i = 0; i < 64; i++) pm[i] = (i == 0) ? 0 : 1000;
    s = '0;
    for (int t = 0; t < 64; t++) begin
      b  = msg[63-t];
      w  = {b, s};
      e0 = ^(w & G0);
      e1 = ^(w & G1);
      s  = {b, s[5:1]};
      word = '0;
      for (int ns = 0; ns < 64; ns++) begin
        ns6  = ns[5:0];
        best = 0;
        bd   = 1'b0;
        for (int d = 0; d < 2; d++) begin
          ps = {ns6[4:0], d[0]};
          w  = {ns6[5], ps};
          m  = pm[ps] + int'((^(w & G0)) != e0) + int'((^(w & G1)) != e1);
          if (d == 0 || m < best) begin best = m; bd = d[0]; end
        end
        npm[ns]  = best;
        word[ns] = bd;
      end
      pm = npm;
      mem[(10 + t) % 128] = word;
    end
    run_block(7'd73, s, 0, 0, 0, 7'd0, 6'd0);
    checks++; if (got_vec() !== want || got_bits.size() != 32) begin errors++; $display("FAIL t3_golden: got %h (%0d bits) want %h", got_vec(), got_bits.size(), want); end
  endtask

  task automatic test_wrap();
    logic [63:0] tmp [0:127];
    logic [31:0] first;
    logic [5:0]  st;
    st = 6'($urandom);
    fill_mem(2);
    ref_model(7'd5, st);
    run_block(7'd5, st, 0, 0, 0, 7'd0, 6'd0);
    first = got_vec();
    checks++; if (raddr_bad(7'd5) != 0) begin errors++; $display("FAIL t4_raddr: %0d wrong addresses", raddr_bad(7'd5)); end
    checks++; if (first !== exp_vec()) begin errors++; $display("FAIL t4_wrap_bits: got %h want %h", first, exp_vec()); end
    for (int i = 0; i < 128; i++) tmp[i] = mem[i];
    for (int i = 0; i < 128; i++) mem[(i + 64) % 128] = tmp[i];
    run_block(7'd69, st, 0, 0, 0, 7'd0, 6'd0);
    checks++; if (got_vec() !== first) begin errors++; $display("FAIL t4_unwrapped: got %h want %h", got_vec(), first); end
  endtask

  task automatic test_stall_mid_start();
    logic [6:0] a;
    logic [5:0] st;
    a  = 7'($urandom);
    st = 6'($urandom);
    fill_mem(2);
    ref_model(a, st);
    run_block(a, st, 1, 1, 0, 7'd0, 6'd0);
    checks++; if (got_bits.size() != 32) begin errors++; $display("FAIL t5_count: got %0d want 32", got_bits.size()); end
    checks++; if (got_vec() !== exp_vec()) begin errors++; $display("FAIL t5_bits: got %h want %h", got_vec(), exp_vec()); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL t5_stall_stable: got %0d changes want 0", stall_viol); end
    checks++; if (last_pos() != 31) begin errors++; $display("FAIL t5_last_pos: got %0d want 31", last_pos()); end
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin errors++; $display("FAIL t5_mid_start_ignored: busy=%b valid=%b want 0 0", busy, dout_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    logic [6:0] a;
    logic [5:0] st;
    a  = 7'($urandom_range(1, 127));
    st = 6'($urandom);
    fill_mem(2);
    start = 1'b1;
    start_addr = a;
    start_state = st;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (11) @(posedge clock);
    #1;
    rst_n = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy: got %b want 0", busy); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL t6_valid: got %b want 0", dout_valid); end
    checks++; if (raddr !== 7'd0) begin errors++; $display("FAIL t6_raddr: got %0d want 0", raddr); end
    @(posedge clock); #1;
    a  = 7'($urandom);
    st = 6'($urandom);
    ref_model(a, st);
    run_block(a, st, 0, 0, 0, 7'd0, 6'd0);
    checks++; if (got_vec() !== exp_vec() || got_bits.size() != 32) begin errors++; $display("FAIL t6_fresh_bits: got %h want %h", got_vec(), exp_vec()); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a1;
    logic [6:0] a2;
    logic [5:0] s1;
    logic [5:0] s2;
    a1 = 7'($urandom);
    a2 = 7'($urandom);
    s1 = 6'($urandom);
    s2 = 6'($urandom);
    fill_mem(2);
    ref_model(a1, s1);
    run_block(a1, s1, 0, 0, 1, a2, s2);
    checks++; if (got_vec() !== exp_vec()) begin errors++; $display("FAIL b2b_first: got %h want %h", got_vec(), exp_vec()); end
    ref_model(a2, s2);
    run_block(a2, s2, 0, 0, 0, 7'd0, 6'd0);
    checks++; if (got_vec() !== exp_vec() || got_bits.size() != 32) begin errors++; $display("FAIL b2b_second: got %h want %h", got_vec(), exp_vec()); end
    checks++; if (first_valid_k != N + 2) begin errors++; $display("FAIL b2b_first_valid: got c0+%0d want c0+%0d", first_valid_k, N + 2); end
  endtask

  task automatic test_random();
    logic [6:0] a;
    logic [5:0] st;
    for (int it = 0; it < 4; it++) begin
      a  = 7'($urandom);
      st = 6'($urandom);
      fill_mem(2);
      ref_model(a, st);
      run_block(a, st, 2, 0, 0, 7'd0, 6'd0);
      checks++; if (got_vec() !== exp_vec() || got_bits.size() != 32) begin errors++; $display("FAIL rand_bits[%0d]: got %h want %h", it, got_vec(), exp_vec()); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall[%0d]: got %0d changes want 0", it, stall_viol); end
      checks++; if (raddr_bad(a) != 0) begin errors++; $display("FAIL rand_raddr[%0d]: %0d wrong addresses", it, raddr_bad(a)); end
    end
  endtask

  initial begin
    fill_mem(0);
    test_reset();
    test_zeros();
    test_ones();
    test_golden();
    test_wrap();
    test_stall_mid_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
